// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the fetch stage.
//  word_t        : 32-bit machine word
//  fetch_state_t : fetch FSM states (FETCH, HOLD, HALTED)
//  PC_INIT_DEFAULT / NOP_DEFAULT : reset PC and the bubble word (sll $0,$0,0)
//  word_align()  : clears the byte-offset bits of an address
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;
  localparam word_t NOP_DEFAULT     = 32'h0000_0000;

  function automatic word_t word_align(input word_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_reg.sv
// Program counter register with next-PC selection.
//  clk_i, rst_ni : clock, async active-low reset (PC <= PC_INIT)
//  load_i        : load word-aligned load_pc_i (highest priority)
//  load_pc_i     : redirect target
//  inc_i         : advance PC by 4 (modulo 2^32)
//  pc_o          : current PC
//  pc_plus4_o    : PC + 4
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  load_i,
  input  word_t load_pc_i,
  input  logic  inc_i,
  output word_t pc_o,
  output word_t pc_plus4_o
);

  word_t pc_d, pc_q;

  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_o       = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = word_align(load_pc_i);
    end else if (inc_i) begin
      pc_d = pc_plus4_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= PC_INIT;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, drives the icache request and the IF/ID register.
//  CLK, nRST             : clock, async active-low reset
//  ihit, imemload        : icache hit and read data for imemaddr
//  imemREN, imemaddr     : icache read enable and address (= PC)
//  stall                 : decode hazard, hold PC and IF/ID
//  redirect, redirect_pc : taken branch/jump from a later stage, flushes IF/ID
//  halt                  : halt decoded in IF/ID, freezes fetch until reset
//  instruction, pc_plus4 : IF/ID contents
//  if_valid              : IF/ID holds a real fetched instruction
//  halted                : fetch frozen
module instr_fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT  = PC_INIT_DEFAULT,
  parameter word_t NOP_WORD = NOP_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output word_t instruction,
  output word_t pc_plus4,
  output logic  if_valid,
  output logic  halted
);

  fetch_state_t state_d, state_q;
  word_t        instr_d, instr_q;
  word_t        pc4_d, pc4_q;
  logic         valid_d, valid_q;
  word_t        buf_d, buf_q;

  word_t pc, pc_next_seq;
  logic  pc_load, pc_inc;

  pc_reg #(
    .PC_INIT(PC_INIT)
  ) u_pc_reg (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .load_i    (pc_load),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc),
    .pc_plus4_o(pc_next_seq)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          // A hit in the same cycle belongs to the wrong path and is dropped.
          pc_load = 1'b1;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (halt) begin
          state_d = HALTED;
        end else if (stall) begin
          // Park the hit so the icache need not be re-accessed.
          if (ihit) begin
            buf_d   = imemload;
            state_d = HOLD;
          end
        end else if (ihit) begin
          instr_d = imemload;
          pc4_d   = pc_next_seq;
          valid_d = 1'b1;
          pc_inc  = 1'b1;
        end else begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          instr_d = buf_q;
          pc4_d   = pc_next_seq;
          valid_d = 1'b1;
          pc_inc  = 1'b1;
          state_d = FETCH;
        end
      end
      HALTED: begin
        // Frozen until reset; redirects cannot arrive once older stages drained.
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
    end
  end

  assign imemREN     = (state_q == FETCH);
  assign imemaddr    = pc;
  assign halted      = (state_q == HALTED);
  assign instruction = instr_q;
  assign pc_plus4    = pc4_q;
  assign if_valid    = valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        if_valid;
  logic        halted;

  instr_fetch_stage dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ihit       (ihit),
    .imemload   (imemload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .instruction(instruction),
    .pc_plus4   (pc_plus4),
    .if_valid   (if_valid),
    .halted     (halted)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Reference model: what the stage must hold after each edge.
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_halted;
  logic [31:0] m_parked[$];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      m_parked.delete();
    end else if (!m_halted) begin
      if (redirect) begin
        m_pc = redirect_pc & ~32'h3;
        m_instr = 32'h0; m_valid = 1'b0;
        m_parked.delete();
      end else if (halt) begin
        m_halted = 1'b1;
        m_parked.delete();
      end else if (m_parked.size() != 0) begin
        if (!stall) begin
          m_instr = m_parked.pop_front();
          m_p4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end else if (stall) begin
        if (ihit) m_parked.push_back(imemload);
      end else if (ihit) begin
        m_instr = imemload; m_p4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
    end
  end

  // Hand-computed expectations; mask bits: 0 ren,1 addr,2 instr,3 p4,4 valid,5 halted
  logic        pin_on = 1'b0;
  logic [5:0]  pin_mask;
  logic        pin_ren, pin_valid, pin_halted;
  logic [31:0] pin_addr, pin_instr, pin_p4;
  string       pin_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model.imemREN", {31'b0, imemREN},
          {31'b0, (!m_halted && m_parked.size() == 0)});
      chk("model.imemaddr", imemaddr, m_pc);
      chk("model.instruction", instruction, m_instr);
      chk("model.pc_plus4", pc_plus4, m_p4);
      chk("model.if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("model.halted", {31'b0, halted}, {31'b0, m_halted});
      if (pin_on) begin
        if (pin_mask[0]) chk({pin_tag, ".imemREN"}, {31'b0, imemREN}, {31'b0, pin_ren});
        if (pin_mask[1]) chk({pin_tag, ".imemaddr"}, imemaddr, pin_addr);
        if (pin_mask[2]) chk({pin_tag, ".instruction"}, instruction, pin_instr);
        if (pin_mask[3]) chk({pin_tag, ".pc_plus4"}, pc_plus4, pin_p4);
        if (pin_mask[4]) chk({pin_tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, pin_valid});
        if (pin_mask[5]) chk({pin_tag, ".halted"}, {31'b0, halted}, {31'b0, pin_halted});
      end
    end
  end

  // Drive one cycle of inputs just after the falling edge.
  task automatic cyc(input logic ih, input logic [31:0] ld, input logic st,
                     input logic rd, input logic [31:0] rpc, input logic hl);
    @(negedge CLK);
    #1;
    pin_on = 1'b0;
    ihit = ih; imemload = ld; stall = st; redirect = rd; redirect_pc = rpc; halt = hl;
  endtask

  // Expectations for the outputs seen at the next falling edge.
  task automatic pin(input string tag, input logic [5:0] mask, input logic ren,
                     input logic [31:0] addr, input logic [31:0] ins, input logic [31:0] p4,
                     input logic vld, input logic hlt);
    pin_tag = tag; pin_mask = mask; pin_ren = ren; pin_addr = addr; pin_instr = ins;
    pin_p4 = p4; pin_valid = vld; pin_halted = hlt; pin_on = 1'b1;
  endtask

  // Reset pulse wholly inside the low clock phase.
  task automatic reset_pulse();
    @(negedge CLK);
    #1;
    pin_on = 1'b0;
    ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; imemload = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    repeat (2) @(posedge CLK);
    chk_en = 1'b1;
    pin("reset", 6'b111111, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    pin_on = 1'b0;
    nRST = 1'b1;

    // 1: first fetch
    cyc(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0, 1'b0);
    pin("t1", 6'b011111, 1'b1, 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0);
    // 2: misses at PC 8
    cyc(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0);
    pin("t2.pc8", 6'b000010, 1'b1, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
      pin("t2.bubble", 6'b010110, 1'b1, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    cyc(1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0);
    pin("t2.fetch", 6'b011110, 1'b1, 32'hC, 32'h2222_2222, 32'hC, 1'b1, 1'b0);
    // 3: stall with hit parks the word
    cyc(1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0, 1'b0);
    pin("t3.hold", 6'b011111, 1'b0, 32'hC, 32'h2222_2222, 32'hC, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    pin("t3.held", 6'b000111, 1'b0, 32'hC, 32'h2222_2222, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    pin("t3.release", 6'b011111, 1'b1, 32'h10, 32'h3333_3333, 32'h10, 1'b1, 1'b0);
    // 4: redirect beats stall and hit
    cyc(1'b1, 32'h4444_4444, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    pin("t4", 6'b010111, 1'b1, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    // 5: halt freezes; misaligned target is aligned
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0023, 1'b0);
    pin("t5.align", 6'b000010, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b1);
    pin("t5.halt", 6'b110111, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, $urandom, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      pin("t5.frozen", 6'b110111, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    reset_pulse();
    pin("t5.reset", 6'b110011, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    // 6: PC wrap, then reset during a miss and during HOLD
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    pin("t6.top", 6'b000010, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0, 1'b0);
    pin("t6.wrap", 6'b011110, 1'b1, 32'h0, 32'h6666_6666, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    reset_pulse();
    pin("t6.miss_rst", 6'b111111, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h8888_8888, 1'b1, 1'b0, 32'h0, 1'b0);
    pin("t6.hold", 6'b000001, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset_pulse();
    pin("t6.hold_rst", 6'b010111, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 4) begin
        reset_pulse();
      end else begin
        logic [31:0] rpc;
        rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
        cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 2,
            $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 199) == 0);
      end
    end
    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
